// File: rtl/pipe_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Holds the shift-mode encoding used by the per-level shift decoder.
package pipe_shifter_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] SH_SLL = 3'b000;  // logical left, zero fill
  localparam logic [MODE_W-1:0] SH_SRL = 3'b001;  // logical right, zero fill
  localparam logic [MODE_W-1:0] SH_SRA = 3'b010;  // arithmetic right, sign fill
  localparam logic [MODE_W-1:0] SH_ROL = 3'b011;  // rotate left
  localparam logic [MODE_W-1:0] SH_ROR = 3'b100;  // rotate right

endpackage

// File: rtl/pipe_shifter_shift_stage.sv
// shift_stage: one combinational level of the barrel shifter.
// Ports:
//   i_data  operand entering this level
//   i_fill  bit shifted in on right shifts (already 0 unless SRA)
//   i_en    amount bit for this level; 0 passes the operand through
//   i_mode  shift mode
//   o_data  operand after this level
module shift_stage
  import pipe_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_fill,
  input  logic              i_en,
  input  logic [MODE_W-1:0] i_mode,
  output logic [WIDTH-1:0]  o_data
);

  // SRL and SRA share one path: the carried fill bit already encodes the difference.
  always_comb begin
    o_data = i_data;
    if (i_en) begin
      case (i_mode)
        SH_SLL:         o_data = i_data << DIST;
        SH_SRL, SH_SRA: o_data = {{DIST{i_fill}}, i_data[WIDTH-1:DIST]};
        SH_ROL:         o_data = (i_data << DIST) | (i_data >> (WIDTH - DIST));
        SH_ROR:         o_data = (i_data >> DIST) | (i_data << (WIDTH - DIST));
        default:        o_data = i_data;
      endcase
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// pipe_shifter: pipelined barrel shifter, one register per log2 shift level,
// largest distance first, with a valid/ready handshake on both sides.
// Ports:
//   clk, clrn            clock, asynchronous active-low reset
//   flush                synchronous kill of every in-flight operand
//   in_valid/in_ready    input handshake
//   in_d/in_sa/in_mode   operand, shift amount, mode
//   in_tag               pass-through tag
//   out_valid/out_ready  output handshake
//   out_sh/out_tag       result and its tag
module pipe_shifter
  import pipe_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_d,
  input  logic [$clog2(WIDTH)-1:0] in_sa,
  input  logic [MODE_W-1:0]        in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sh,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int unsigned SHW = $clog2(WIDTH);

  // Per-stage registers
  logic [SHW-1:0]    r_valid;
  logic [WIDTH-1:0]  r_data [SHW];
  logic [TAG_W-1:0]  r_tag  [SHW];
  logic [MODE_W-1:0] r_mode [SHW];
  logic [SHW-1:0]    r_sa   [SHW];
  logic              r_fill [SHW];

  // Per-stage sources (input port for stage 0, previous register otherwise)
  logic [SHW-1:0]    w_src_valid;
  logic [WIDTH-1:0]  w_src_data [SHW];
  logic [TAG_W-1:0]  w_src_tag  [SHW];
  logic [MODE_W-1:0] w_src_mode [SHW];
  logic [SHW-1:0]    w_src_sa   [SHW];
  logic              w_src_fill [SHW];
  logic [WIDTH-1:0]  w_shift    [SHW];
  logic [SHW-1:0]    w_ready;

  // Ready chain, walked from the output back: a stage can load if empty or draining.
  always_comb begin
    logic v_rdy;
    v_rdy   = out_ready;
    w_ready = '0;
    for (int k = SHW - 1; k >= 0; k--) begin
      v_rdy      = !r_valid[k] | v_rdy;
      w_ready[k] = v_rdy;
    end
  end

  assign in_ready = w_ready[0] & !flush;

  // Stage sources; the fill bit is resolved once here and travels with the operand.
  always_comb begin
    w_src_valid[0] = in_valid & in_ready;
    w_src_data[0]  = in_d;
    w_src_tag[0]   = in_tag;
    w_src_mode[0]  = in_mode;
    w_src_sa[0]    = in_sa;
    w_src_fill[0]  = in_d[WIDTH-1] & (in_mode == SH_SRA);
    for (int k = 1; k < SHW; k++) begin
      w_src_valid[k] = r_valid[k-1];
      w_src_data[k]  = r_data[k-1];
      w_src_tag[k]   = r_tag[k-1];
      w_src_mode[k]  = r_mode[k-1];
      w_src_sa[k]    = r_sa[k-1];
      w_src_fill[k]  = r_fill[k-1];
    end
  end

  // Stage k shifts by 2^(SHW-1-k) under amount bit SHW-1-k.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << (SHW - 1 - k))
    ) u_stage (
      .i_data (w_src_data[k]),
      .i_fill (w_src_fill[k]),
      .i_en   (w_src_sa[k][SHW-1-k]),
      .i_mode (w_src_mode[k]),
      .o_data (w_shift[k])
    );
  end

  // Pipeline registers; flush kills valids only, payload may go stale.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_valid <= '0;
      for (int k = 0; k < SHW; k++) begin
        r_data[k] <= '0;
        r_tag[k]  <= '0;
        r_mode[k] <= '0;
        r_sa[k]   <= '0;
        r_fill[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (flush) begin
          r_valid[k] <= 1'b0;
        end else if (w_ready[k]) begin
          r_valid[k] <= w_src_valid[k];
        end
        if (w_ready[k]) begin
          r_data[k] <= w_shift[k];
          r_tag[k]  <= w_src_tag[k];
          r_mode[k] <= w_src_mode[k];
          r_sa[k]   <= w_src_sa[k];
          r_fill[k] <= w_src_fill[k];
        end
      end
    end
  end

  assign out_valid = r_valid[SHW-1];
  assign out_sh    = r_data[SHW-1];
  assign out_tag   = r_tag[SHW-1];

endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter (WIDTH=32): accepted inputs push a model
// result, the monitor pops and compares on every output transfer.
module tb_pipe_shifter;

  logic        clk;
  logic        clrn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_d;
  logic [4:0]  in_sa;
  logic [2:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sh;
  logic [4:0]  out_tag;

  pipe_shifter #(.WIDTH(32), .TAG_W(5)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_d      (in_d),
    .in_sa     (in_sa),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sh    (out_sh),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  tag;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_out    = 0;
  int          n_acc    = 0;
  logic [4:0]  tag_ctr  = '0;
  bit          hold_pending = 0;
  logic [31:0] hold_sh;
  logic [4:0]  hold_tag;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, req);
  endtask

  // Reference shifter written directly from the mode definitions.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sa,
                                            input logic [2:0] mode);
    logic [63:0] dd;
    dd = {d, d};
    case (mode)
      3'd0:    return d << sa;
      3'd1:    return d >> sa;
      3'd2:    return $unsigned($signed(d) >>> sa);
      3'd3:    begin dd = dd << sa; return dd[63:32]; end
      3'd4:    begin dd = dd >> sa; return dd[31:0]; end
      default: return d;
    endcase
  endfunction

  // Monitor and scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!clrn) begin
      hold_pending = 0;
    end else begin
      if (hold_pending && out_valid) begin
        check("hold_sh", 64'(out_sh), 64'(hold_sh));
        check("hold_tag", 64'(out_tag), 64'(hold_tag));
      end
      hold_pending = out_valid && !out_ready;
      hold_sh      = out_sh;
      hold_tag     = out_tag;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("no_pending_out", 64'(out_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          check("res_sh", 64'(out_sh), 64'(e.d));
          check("res_tag", 64'(out_tag), 64'(e.tag));
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        sb.push_back('{d: ref_shift(in_d, in_sa, in_mode), tag: in_tag});
        n_acc++;
        tag_ctr = tag_ctr + 5'd1;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_item();
    in_d    = $urandom;
    in_sa   = 5'($urandom_range(0, 31));
    in_mode = 3'($urandom_range(0, 7));
    in_tag  = tag_ctr;
  endtask

  task automatic drain();
    int cnt;
    in_valid  = 0;
    out_ready = 1;
    cnt = 0;
    while (sb.size() != 0 && cnt < 100) begin
      next_cycle();
      cnt++;
    end
    check("drain_done", 64'(sb.size()), 64'(0));
    repeat (2) next_cycle();
  endtask

  // One item into an empty pipe with out_ready=1; checks latency and result.
  task automatic directed(input string nm, input logic [31:0] d, input logic [4:0] sa,
                          input logic [2:0] mode, input logic [31:0] req);
    int cnt;
    bit seen;
    out_ready = 1;
    in_valid  = 1;
    in_d      = d;
    in_sa     = sa;
    in_mode   = mode;
    in_tag    = tag_ctr;
    @(negedge clk);
    check({nm, "_in_ready"}, 64'(in_ready), 64'(1));
    next_cycle();
    in_valid = 0;
    cnt  = 0;
    seen = 0;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (out_valid) seen = 1;
    end
    check({nm, "_latency"}, 64'(cnt), 64'(5));
    check({nm, "_data"}, 64'(out_sh), 64'(req));
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    int a0, o0;
    clrn      = 0;
    flush     = 0;
    in_valid  = 0;
    in_d      = '0;
    in_sa     = '0;
    in_mode   = '0;
    in_tag    = '0;
    out_ready = 1;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_sh", 64'(out_sh), 64'(0));
    check("rst_out_tag", 64'(out_tag), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #2 clrn = 1;
    repeat (2) next_cycle();

    // Directed shifts
    directed("sra",  32'h80000000, 5'd4,  3'b010, 32'hF8000000);
    directed("srl",  32'h80000000, 5'd4,  3'b001, 32'h08000000);
    directed("rol",  32'h80000001, 5'd1,  3'b011, 32'h00000003);
    directed("ror",  32'h00000001, 5'd31, 3'b100, 32'h00000002);
    directed("sll",  32'h00000001, 5'd31, 3'b000, 32'h80000000);
    directed("pass", 32'h12345678, 5'd7,  3'b111, 32'h12345678);
    directed("sra0", 32'h80000000, 5'd0,  3'b010, 32'h80000000);

    // Backpressure: 5 accepts then stall, tags 0..4
    tag_ctr   = '0;
    out_ready = 0;
    a0 = n_acc;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1;
      rand_item();
      next_cycle();
    end
    check("bp_accepts", 64'(n_acc - a0), 64'(5));
    @(negedge clk);
    check("bp_in_ready", 64'(in_ready), 64'(0));
    next_cycle();
    out_ready = 1;
    rand_item();
    o0 = n_out;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      rand_item();
    end
    check("bp_throughput", 64'(n_out - o0), 64'(12));
    drain();

    // Bubble collapse
    out_ready = 0;
    in_valid  = 1;
    rand_item();
    next_cycle();
    in_valid = 0;
    repeat (2) next_cycle();
    in_valid = 1;
    rand_item();
    next_cycle();
    in_valid = 0;
    repeat (6) next_cycle();
    @(negedge clk);
    check("bubble_in_ready", 64'(in_ready), 64'(1));
    next_cycle();
    out_ready = 1;
    o0 = n_out;
    next_cycle();
    check("bubble_first", 64'(n_out - o0), 64'(1));
    @(negedge clk);
    check("bubble_second_valid", 64'(out_valid), 64'(1));
    next_cycle();
    drain();

    // Flush with 3 in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      rand_item();
      next_cycle();
    end
    out_ready = 0;
    flush     = 1;
    rand_item();
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'(0));
    next_cycle();
    flush     = 0;
    in_valid  = 0;
    sb.delete();
    out_ready = 1;
    o0 = n_out;
    repeat (8) next_cycle();
    check("flush_no_out", 64'(n_out - o0), 64'(0));
    directed("flush_next", 32'h0000F00F, 5'd8, 3'b011, 32'h00F00F00);

    // Async reset with 4 in flight
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      rand_item();
      next_cycle();
    end
    in_valid = 0;
    repeat (6) next_cycle();
    #1 clrn = 0;
    sb.delete();
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_out_sh", 64'(out_sh), 64'(0));
    check("arst_out_tag", 64'(out_tag), 64'(0));
    @(posedge clk);
    #2 clrn = 1;
    next_cycle();
    out_ready = 1;
    o0 = n_out;
    repeat (10) next_cycle();
    check("arst_no_out", 64'(n_out - o0), 64'(0));
    directed("arst_next", 32'h80000000, 5'd31, 3'b010, 32'hFFFFFFFF);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 65);
      rand_item();
      next_cycle();
    end
    drain();
    check("final_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
